// File: rtl/mont_pkg.sv
// Shared constants and FSM encoding for the bit-serial Montgomery multiplier.
// The optional final reduction is selected with the MONT_FINAL_SUB_EN macro.
package mont_pkg;

    localparam int DEFAULT_WIDTH = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        FINAL
    } state_e;

    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/mont_cond_sub.sv
// Final Montgomery reduction: subtracts the modulus once when the accumulator reaches it.
// Instantiated by mont_mul_core only when MONT_FINAL_SUB_EN is defined.
import mont_pkg::*;

module mont_cond_sub #(
    parameter int W = DEFAULT_WIDTH + 2
) (
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] r_o
);

    assign r_o = (c_i >= m_i) ? (c_i - m_i) : c_i;

endmodule

// File: rtl/mont_mul_core.sv
// Radix-2 bit-serial Montgomery multiplier, one multiplier bit per clock.
// MONT_FINAL_SUB_EN enables the conditional subtraction so the result lands in [0, m).
import mont_pkg::*;

module mont_mul_core #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [WIDTH-1:0] in_m_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    localparam int CntW = cntWidth(WIDTH);

    state_e            stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [WIDTH+1:0]  cQ, cD;
    logic [WIDTH-1:0]  aQ, aD;
    logic [WIDTH-1:0]  bQ, bD;
    logic [WIDTH-1:0]  mQ, mD;
    logic [WIDTH-1:0]  resultQ, resultD;
    logic              doneQ, doneD;

    logic [WIDTH+1:0]  tAdd;
    logic [WIDTH+1:0]  tRed;
    logic [WIDTH-1:0]  finalVal;

    // C < 2m keeps both additions inside WIDTH+2 bits, so no carry is lost.
    assign tAdd = cQ + (bQ[cntQ] ? {2'b00, aQ} : '0);
    assign tRed = tAdd + (tAdd[0] ? {2'b00, mQ} : '0);

`ifdef MONT_FINAL_SUB_EN
    logic [WIDTH+1:0] subOut;
    logic [1:0]       unusedSubHi;

    mont_cond_sub #(
        .W (WIDTH + 2)
    ) u_cond_sub (
        .c_i (cQ),
        .m_i ({2'b00, mQ}),
        .r_o (subOut)
    );

    assign {unusedSubHi, finalVal} = subOut;
`else
    assign finalVal = cQ[WIDTH-1:0];
`endif

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        cD      = cQ;
        aD      = aQ;
        bD      = bQ;
        mD      = mQ;
        resultD = resultQ;
        doneD   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start_i) begin
                    aD     = in_a_i;
                    bD     = in_b_i;
                    mD     = in_m_i;
                    cD     = '0;
                    cntD   = '0;
                    stateD = LOOP;
                end
            end
            LOOP: begin
                cD   = tRed >> 1;
                cntD = cntQ + 1'b1;
                if (cntQ == CntW'(WIDTH - 1)) begin
                    stateD = FINAL;
                end
            end
            FINAL: begin
                resultD = finalVal;
                doneD   = 1'b1;
                stateD  = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            cQ      <= '0;
            aQ      <= '0;
            bQ      <= '0;
            mQ      <= '0;
            resultQ <= '0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            cQ      <= cD;
            aQ      <= aD;
            bQ      <= bD;
            mQ      <= mD;
            resultQ <= resultD;
            doneQ   <= doneD;
        end
    end

    assign result_o = resultQ;
    assign done_o   = doneQ;

endmodule

// File: tb/tb_mont_mul_core.sv
// Directed and random checks of mont_mul_core at WIDTH=8.
// Without MONT_FINAL_SUB_EN the result may legitimately be one modulus above the reference.
module tb_mont_mul_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] inA, inB, inM;
    logic [W-1:0] result;
    logic         done;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    mont_mul_core #(
        .WIDTH (W)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .in_a_i   (inA),
        .in_b_i   (inB),
        .in_m_i   (inM),
        .result_o (result),
        .done_o   (done)
    );

    task automatic checkOutput(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkResult(input string name, input int got, input int refVal, input int m);
        bit ok;
        compared++;
`ifdef MONT_FINAL_SUB_EN
        ok = (got == refVal);
`else
        ok = (got == refVal) || (got == ((refVal + m) & 255));
`endif
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (m=%0d)", name, got, refVal, m);
        end
    endtask

    // Leaves the caller just after the edge that sampled start.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        @(negedge clk);
        start = 1'b1;
        inA   = a;
        inB   = b;
        inM   = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        inA   = 8'hAA;
        inB   = 8'h55;
        inM   = 8'h3C;
    endtask

    task automatic waitDone(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    function automatic int refMont(input int a, input int b, input int m);
        int p;
        int r;
        p = (a * b) % m;
        r = 0;
        for (int x = 0; x < m; x++) begin
            if (((x * 256) % m) == p) r = x;
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int doneCount;
        int firstEdge;
        bit holdBad;
        int a, b, m, r;

        vecs[0] = '{8'd5,   8'd7,   8'd239, 8'd227};
        vecs[1] = '{8'd17,  8'd17,  8'd239, 8'd17};
        vecs[2] = '{8'd17,  8'd1,   8'd239, 8'd1};
        vecs[3] = '{8'd0,   8'd200, 8'd239, 8'd0};
        vecs[4] = '{8'd1,   8'd1,   8'd239, 8'd225};
        vecs[5] = '{8'd238, 8'd238, 8'd239, 8'd225};
        vecs[6] = '{8'd1,   8'd17,  8'd239, 8'd1};

        reset = 1'b1;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        inM   = '0;
        #1;
        checkOutput("reset_result", result, 0);
        checkOutput("reset_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m);
            waitDone(edges);
            checkOutput($sformatf("vec%0d_latency", i), edges, 9);
            checkResult($sformatf("vec%0d_result", i), result, vecs[i].exp, vecs[i].m);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Back-to-back: second start lands in the done cycle of the first.
        applyStimulus(8'd0, 8'd200, 8'd239);
        waitDone(edges);
        checkOutput("b2b_first_latency", edges, 9);
        checkResult("b2b_first_result", result, 0, 239);
        applyStimulus(8'd5, 8'd7, 8'd239);
        edges   = -1;
        holdBad = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
            if (result != 0) holdBad = 1'b1;
        end
        checkOutput("b2b_second_latency", edges, 9);
        checkOutput("b2b_hold_zero", holdBad, 0);
        checkResult("b2b_second_result", result, 227, 239);

        // Busy protection: a second start during LOOP is ignored.
        applyStimulus(8'd5, 8'd7, 8'd239);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        inA   = 8'd1;
        inB   = 8'd1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        doneCount = 0;
        firstEdge = -1;
        for (int i = 5; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                doneCount++;
                if (firstEdge < 0) firstEdge = i;
            end
        end
        checkOutput("busy_done_count", doneCount, 1);
        checkOutput("busy_latency", firstEdge, 9);
        checkResult("busy_result", result, 227, 239);

        // Mid-operation reset at edge k+3.
        applyStimulus(8'd17, 8'd17, 8'd239);
        repeat (2) @(posedge clk);
        @(posedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_result", result, 0);
        checkOutput("midrst_done", done, 0);
        @(negedge clk);
        reset     = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", doneCount, 0);
        applyStimulus(8'd5, 8'd7, 8'd239);
        waitDone(edges);
        checkOutput("midrst_fresh_latency", edges, 9);
        checkResult("midrst_fresh_result", result, 227, 239);

        for (int n = 0; n < 1000; n++) begin
            m = 2 * $urandom_range(1, 63) + 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            r = refMont(a, b, m);
            applyStimulus(8'(a), 8'(b), 8'(m));
            waitDone(edges);
            checkOutput($sformatf("rand%0d_latency", n), edges, 9);
            checkResult($sformatf("rand%0d_result a=%0d b=%0d", n, a, b), result, r, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mont_mul_core.md
# mont_mul_core

Radix-2 bit-serial Montgomery multiplier: the responder side of the `start`/`done` multiply handshake used by the modular-exponentiation controller. It computes `result = in_a * in_b * 2^-WIDTH mod in_m` for odd `in_m`, one multiplier bit per clock. The controller pulses `start` with operands valid, then waits for a one-cycle `done`.

## Interface
- `WIDTH`, default 1024: operand and modulus width in bits. The Montgomery constant is R = 2^WIDTH.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request. Operands are valid only in this cycle.
- `in_a` in WIDTH: multiplicand; requires `in_a < in_m`.
- `in_b` in WIDTH: multiplier, scanned LSB first; requires `in_b < in_m`.
- `in_m` in WIDTH: modulus; must be odd and satisfy `in_m < 2^(WIDTH-1)`.
- `result` out WIDTH: product, registered; held until the next completion.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.

## Operation
- FSM states:
  - `IDLE`: waits for a request. On `start`, latch `in_a`, `in_b` and `in_m` into internal registers, clear accumulator C (WIDTH+2 bits), set `cnt` = 0, go to `LOOP`.
  - `LOOP`: each cycle, compute `t = C + (b[cnt] ? a : 0)`, then `t = t + (t[0] ? m : 0)`, then `C <= t >> 1`; increment `cnt`. After the iteration with `cnt == WIDTH-1`, go to `FINAL`.
  - `FINAL`: `result <= (C >= m) ? C - m : C` (see Configuration), `done <= 1`, go to `IDLE`.
- Invariant: `C < 2m` after every iteration. All intermediate sums fit in WIDTH+2 bits. Truncating `result` to WIDTH bits is lossless.
- `start` in `LOOP` or `FINAL` is ignored. No error is flagged and the latched operands are unchanged.
- `start` in the cycle `done` is high is accepted, because the FSM is already in `IDLE`. This allows back-to-back requests.
- Input changes outside the `start` cycle have no effect.
- Even `in_m` is outside the contract and the result is undefined. The FSM still completes in normal latency.

## Timing
- Reset values: `result` = 0, `done` = 0, FSM = `IDLE`, `cnt` = 0, C and the operand registers = 0.
- `start` is sampled at edge k.
  - Iterations run at edges k+1 through k+WIDTH.
  - `FINAL` executes at edge k+WIDTH+1.
  - `done` is high for exactly the cycle following edge k+WIDTH+1.
- Latency is WIDTH+1 edges from start to done, and is data-independent.
- Throughput: one multiply per WIDTH+1 cycles.
- `done` is registered and never high for two consecutive cycles.
- Reset asserted mid-operation: everything returns to reset values asynchronously and no `done` is produced. The first `start` after reset deassertion is accepted normally.

## Configuration
- `MONT_FINAL_SUB_EN`
  - Defined (project default): `FINAL` performs the conditional subtraction, so `result` is in [0, m).
  - Undefined: `FINAL` writes `C[WIDTH-1:0]` directly. `result` is in [0, 2m) and congruent to the true value mod m. This removes the WIDTH+2-bit comparator and subtractor.
  - Latency and handshake are identical in both builds.

## Structure
- Package `mont_pkg` holds:
  - the default `WIDTH` constant;
  - the FSM state enum (`IDLE`, `LOOP`, `FINAL`);
  - the counter width constant, `$clog2(WIDTH)`.
- Sub-module `mont_cond_sub`: combinational `C >= m ? C - m : C` on WIDTH+2 bits. It is instantiated only under `MONT_FINAL_SUB_EN`.
- The datapath adders and the FSM stay in `mont_mul_core`.

## Test plan
All cases use WIDTH=8 and m=239, so R mod m = 17 and R^-1 mod m = 225.
- Basic multiply: a=5, b=7, pulse `start` → `done` exactly 9 edges later, `result` = 227.
- Identity: a=17, b=17 → `result` = 17. Then a=17, b=1 → `result` = 1 (conversion out of Montgomery domain).
- Zero and back-to-back: a=0, b=200 → `result` = 0. Re-pulse `start` in the `done` cycle with a=5, b=7 → second `done` 9 edges later with 227, and `result` holds 0 in between.
- Busy protection: pulse `start` with a=5, b=7, then pulse `start` with a=1, b=1 at edge k+4 → only one `done`, `result` = 227.
- Mid-operation reset: assert `reset` at edge k+3 → `result` = 0 and `done` = 0 immediately, with no later `done`. A fresh request completes correctly.
- Random sweep, 1000 odd m < 128 and a, b < m, against a reference model:
  - With `MONT_FINAL_SUB_EN`: exact match.
  - Without it: `result` is either the reference value or the reference value + m.
  - Both builds: latency is always 9.
